// File: rtl/sprite_sched_pkg.sv
// -----------------------------------------------------------------------------
// sprite_sched_pkg
// Shared types and constants for the sprite scheduler and its blit engine:
// scheduler state encoding, sprite/coordinate/colour widths, the erase colour
// and the per-axis overlap helper used by the optional collision detector.
// -----------------------------------------------------------------------------
package sprite_sched_pkg;

    localparam int SPRITE_DIM = 4;
    localparam int COORD_W    = 7;
    localparam int COLOUR_W   = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_BLACK = 3'b000;

    // Scheduler state encoding (plain constants so legacy code can compare them).
    typedef logic [2:0] sched_state_t;
    localparam sched_state_t ST_IDLE  = 3'd0;
    localparam sched_state_t ST_SNAP  = 3'd1;
    localparam sched_state_t ST_ERASE = 3'd2;
    localparam sched_state_t ST_DRAW  = 3'd3;
    localparam sched_state_t ST_DONE  = 3'd4;

    // True when two coordinates are less than one sprite apart. The difference
    // is taken one bit wider and signed, so there is no wrap-around at 127/0.
    function automatic logic axis_overlap(input logic [COORD_W-1:0] a,
                                          input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return (diff < 8'sd4) && (diff > -8'sd4);
    endfunction

endpackage

// File: rtl/sprite_blit.sv
// -----------------------------------------------------------------------------
// sprite_blit
// Walks the 16 pixels of a 4x4 sprite, one per cycle, starting on start_i.
// Pixel outputs are combinational; the scheduler registers them.
// Ports:
//   clk_i, resetn_i        clock, synchronous active-low reset
//   start_i                begin a blit (only asserted while idle)
//   base_x_i, base_y_i     top-left corner, held stable for the whole blit
//   colour_i               pixel colour
//   plot_o                 a pixel is valid this cycle
//   pix_x_o, pix_y_o       pixel coordinate (wraps mod 128)
//   pix_c_o                pixel colour
//   last_o                 this is the 16th pixel
//   active_o               blit in progress after its first pixel
// -----------------------------------------------------------------------------
module sprite_blit
    import sprite_sched_pkg::*;
(
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                start_i,
    input  logic [COORD_W-1:0]  base_x_i,
    input  logic [COORD_W-1:0]  base_y_i,
    input  logic [COLOUR_W-1:0] colour_i,
    output logic                plot_o,
    output logic [COORD_W-1:0]  pix_x_o,
    output logic [COORD_W-1:0]  pix_y_o,
    output logic [COLOUR_W-1:0] pix_c_o,
    output logic                last_o,
    output logic                active_o
);

    localparam int AXIS_W = $clog2(SPRITE_DIM);
    localparam int OFF_W  = 2 * AXIS_W;

    logic [OFF_W-1:0] off_q, off_d;
    logic             active_q, active_d;
    logic             plot_s, last_s;

    // Pixel generation and offset advance; the first pixel comes out in the start cycle.
    always_comb begin
        plot_s   = start_i | active_q;
        last_s   = plot_s & (off_q == {OFF_W{1'b1}});
        pix_x_o  = base_x_i + COORD_W'(off_q[AXIS_W-1:0]);
        pix_y_o  = base_y_i + COORD_W'(off_q[OFF_W-1:AXIS_W]);
        pix_c_o  = colour_i;
        plot_o   = plot_s;
        last_o   = last_s;
        active_o = active_q;
        if (plot_s) begin
            off_d    = off_q + OFF_W'(1);
            active_d = ~last_s;
        end else begin
            off_d    = off_q;
            active_d = active_q;
        end
    end

    // Offset counter and busy flag.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            off_q    <= '0;
            active_q <= 1'b0;
        end else begin
            off_q    <= off_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_scheduler
// Time-shares one 4x4 blit engine across NUM_SPRITES sprites. On each frame
// tick it snapshots all sprite inputs, erases stale copies in black, then
// redraws moved, recoloured or newly enabled sprites, one pixel per cycle.
// Optional feature macro: SPRITE_SCHED_COLLISION_EN (pairwise overlap flags,
// evaluated at end of frame). Without it, collision is tied low.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   tick                   one-cycle frame pulse
//   spr_en/x/y/c           packed per-sprite enable, position, colour
//   vga_x/y/colour/plot    registered pixel write to the VGA adapter
//   busy                   high from SNAP through DONE
//   frame_done             one-cycle pulse after the last plot of a frame
//   overrun                sticky: tick arrived while not idle
//   collision              per-sprite overlap flags
// -----------------------------------------------------------------------------
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_SPRITES = 4
)
(
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            tick,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    input  logic [COORD_W*NUM_SPRITES-1:0]  spr_x,
    input  logic [COORD_W*NUM_SPRITES-1:0]  spr_y,
    input  logic [COLOUR_W*NUM_SPRITES-1:0] spr_c,
    output logic [COORD_W-1:0]              vga_x,
    output logic [COORD_W-1:0]              vga_y,
    output logic [COLOUR_W-1:0]             vga_colour,
    output logic                            vga_plot,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overrun,
    output logic [NUM_SPRITES-1:0]          collision
);

    localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    sched_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Snapshot taken in SNAP, and the copy of what is currently on screen.
    logic [NUM_SPRITES-1:0]          new_en_q, vis_q;
    logic [COORD_W*NUM_SPRITES-1:0]  new_x_q, new_y_q, old_x_q, old_y_q;
    logic [COLOUR_W*NUM_SPRITES-1:0] new_c_q, old_c_q;

    logic [COORD_W-1:0]  vga_x_q, vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_plot_q, busy_q, frame_done_q, overrun_q;

    logic [COORD_W-1:0]  cur_new_x_s, cur_new_y_s, cur_old_x_s, cur_old_y_s;
    logic [COLOUR_W-1:0] cur_new_c_s, cur_old_c_s;
    logic                pos_chg_s, erase_need_s, draw_need_s, need_s, step_done_s;
    logic [COORD_W-1:0]  blit_bx_s, blit_by_s;
    logic [COLOUR_W-1:0] blit_c_s;
    logic                blit_start_s, blit_plot_s, blit_last_s, blit_active_s;
    logic [COORD_W-1:0]  pix_x_s, pix_y_s;
    logic [COLOUR_W-1:0] pix_c_s;

    // Per-index work decision and blit operand mux.
    always_comb begin
        cur_new_x_s  = new_x_q[idx_q*COORD_W +: COORD_W];
        cur_new_y_s  = new_y_q[idx_q*COORD_W +: COORD_W];
        cur_old_x_s  = old_x_q[idx_q*COORD_W +: COORD_W];
        cur_old_y_s  = old_y_q[idx_q*COORD_W +: COORD_W];
        cur_new_c_s  = new_c_q[idx_q*COLOUR_W +: COLOUR_W];
        cur_old_c_s  = old_c_q[idx_q*COLOUR_W +: COLOUR_W];
        pos_chg_s    = (cur_new_x_s != cur_old_x_s) || (cur_new_y_s != cur_old_y_s);
        erase_need_s = vis_q[idx_q] && (!new_en_q[idx_q] || pos_chg_s);
        draw_need_s  = new_en_q[idx_q] &&
                       (!vis_q[idx_q] || pos_chg_s || (cur_new_c_s != cur_old_c_s));
        case (state_q)
            ST_ERASE: begin
                need_s    = erase_need_s;
                blit_bx_s = cur_old_x_s;
                blit_by_s = cur_old_y_s;
                blit_c_s  = COLOUR_BLACK;
            end
            ST_DRAW: begin
                need_s    = draw_need_s;
                blit_bx_s = cur_new_x_s;
                blit_by_s = cur_new_y_s;
                blit_c_s  = cur_new_c_s;
            end
            default: begin
                need_s    = 1'b0;
                blit_bx_s = cur_new_x_s;
                blit_by_s = cur_new_y_s;
                blit_c_s  = cur_new_c_s;
            end
        endcase
        blit_start_s = need_s && !blit_active_s;
        // An index finishes either on the blit's last pixel or in one skip cycle.
        step_done_s  = need_s ? blit_last_s
                              : ((state_q == ST_ERASE) || (state_q == ST_DRAW));
    end

    sprite_blit u_blit (
        .clk_i    (clk),
        .resetn_i (resetn),
        .start_i  (blit_start_s),
        .base_x_i (blit_bx_s),
        .base_y_i (blit_by_s),
        .colour_i (blit_c_s),
        .plot_o   (blit_plot_s),
        .pix_x_o  (pix_x_s),
        .pix_y_o  (pix_y_s),
        .pix_c_o  (pix_c_s),
        .last_o   (blit_last_s),
        .active_o (blit_active_s)
    );

    // Frame sequencer: all erases, then all draws, each walking indices 0..N-1.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    state_d = ST_SNAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SNAP: begin
                state_d = ST_ERASE;
                idx_d   = '0;
            end
            ST_ERASE: begin
                if (step_done_s && (idx_q == LAST_IDX)) begin
                    state_d = ST_DRAW;
                    idx_d   = '0;
                end else if (step_done_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DRAW: begin
                if (step_done_s && (idx_q == LAST_IDX)) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else if (step_done_s) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State, index, and registered status/pixel outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            vga_plot_q   <= blit_plot_s;
            // busy follows the next state so it lines up with SNAP..DONE.
            busy_q       <= (state_d != ST_IDLE);
            frame_done_q <= (state_q == ST_DONE);
            overrun_q    <= overrun_q | (tick && (state_q != ST_IDLE));
            if (blit_plot_s) begin
                vga_x_q      <= pix_x_s;
                vga_y_q      <= pix_y_s;
                vga_colour_q <= pix_c_s;
            end
        end
    end

    // Sprite snapshot in SNAP and on-screen bookkeeping in DONE.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            new_en_q <= '0;
            new_x_q  <= '0;
            new_y_q  <= '0;
            new_c_q  <= '0;
            old_x_q  <= '0;
            old_y_q  <= '0;
            old_c_q  <= '0;
            vis_q    <= '0;
        end else if (state_q == ST_SNAP) begin
            new_en_q <= spr_en;
            new_x_q  <= spr_x;
            new_y_q  <= spr_y;
            new_c_q  <= spr_c;
        end else if (state_q == ST_DONE) begin
            old_x_q <= new_x_q;
            old_y_q <= new_y_q;
            old_c_q <= new_c_q;
            vis_q   <= new_en_q;
        end
    end

`ifdef SPRITE_SCHED_COLLISION_EN
    logic [NUM_SPRITES-1:0] coll_s, collision_q;
    logic                   hit_s;

    // Pairwise bounding-box overlap over the snapshot, enabled sprites only.
    always_comb begin
        coll_s = '0;
        hit_s  = 1'b0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            for (int j = i + 1; j < NUM_SPRITES; j++) begin
                hit_s = new_en_q[i] && new_en_q[j] &&
                        axis_overlap(new_x_q[i*COORD_W +: COORD_W], new_x_q[j*COORD_W +: COORD_W]) &&
                        axis_overlap(new_y_q[i*COORD_W +: COORD_W], new_y_q[j*COORD_W +: COORD_W]);
                coll_s[i] = coll_s[i] | hit_s;
                coll_s[j] = coll_s[j] | hit_s;
            end
        end
    end

    // Collision flags update alongside frame_done and hold until the next frame end.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            collision_q <= '0;
        end else if (state_q == ST_DONE) begin
            collision_q <= coll_s;
        end
    end

    assign collision = collision_q;
`else
    assign collision = '0;
`endif

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule
